// File: rtl/sorted_stream_stats_pkg.sv
// Shared types and sizing for sorted_stream_stats and dynamic_array_sorter users.
package sorted_stats_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_e;

  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_MAX_ARRAY_SIZE = 16;

  // Width able to hold a count of 0..max_size elements.
  function automatic int unsigned count_width(input int unsigned max_size);
    return $clog2(max_size + 1);
  endfunction

  localparam int unsigned COUNT_WIDTH = $clog2(DEF_MAX_ARRAY_SIZE + 1);
  localparam int unsigned SUM_WIDTH   = DEF_DATA_WIDTH + COUNT_WIDTH;

endpackage

// File: rtl/sorted_stream_stats_if.sv
// Sorted element stream from the array sorter into the statistics block.
interface sorted_stream_stats_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_W      = 5
);
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic [CNT_W-1:0]      expected_size;

  modport master (output valid_in, data_in, expected_size);
  modport slave  (input  valid_in, data_in, expected_size);
endinterface

// File: rtl/sorted_stream_stats_idle_timer.sv
// stats_idle_timer: counts idle cycles, saturating at TIMEOUT-1, which raises expired.
module stats_idle_timer #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic restart,
  output logic expired
);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] cnt_q;

  assign expired = (cnt_q == TW'(TIMEOUT - 1));

  // Idle counter: zeroed on restart/clear, otherwise counts up to the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear || restart) begin
      cnt_q <= '0;
    end else if (!expired) begin
      cnt_q <= cnt_q + TW'(1);
    end
  end
endmodule

// File: rtl/sorted_stream_stats.sv
// sorted_stream_stats: count/min/max/lower median/sum over one sorted burst.
// Optional macro STATS_ORDER_CHECK_EN enables the non-decreasing order check.
module sorted_stream_stats
  import sorted_stats_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter  int unsigned MAX_ARRAY_SIZE = DEF_MAX_ARRAY_SIZE,
  parameter  int unsigned TIMEOUT        = 8,
  localparam int unsigned CW             = count_width(MAX_ARRAY_SIZE),
  localparam int unsigned SW             = DATA_WIDTH + CW
) (
  input  logic                  clk,
  input  logic                  reset,
  sorted_stream_stats_if.slave  s_if,
  input  logic                  clear,
  output logic                  busy,
  output logic                  stats_done,
  output logic [CW-1:0]         count_out,
  output logic [DATA_WIDTH-1:0] min_out,
  output logic [DATA_WIDTH-1:0] max_out,
  output logic [DATA_WIDTH-1:0] median_out,
  output logic [SW-1:0]         sum_out,
  output logic                  order_error,
  output logic                  short_error
);

  state_e        state_q, state_d;
  logic [CW-1:0] exp_q, exp_in;
  logic [CW-1:0] med_idx_q, med_idx_in;
  logic [CW-1:0] idx;
  logic          accept, start, complete, timeout_hit, finish, expired;

  stats_idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear || (state_q != COLLECT)),
    .restart (s_if.valid_in),
    .expired (expired)
  );

  // Burst length as used: 0 means 1, anything above the maximum is clamped.
  always_comb begin
    exp_in = s_if.expected_size;
    if (s_if.expected_size == '0) begin
      exp_in = CW'(1);
    end else if (s_if.expected_size > CW'(MAX_ARRAY_SIZE)) begin
      exp_in = CW'(MAX_ARRAY_SIZE);
    end
    med_idx_in = (exp_in - CW'(1)) >> 1;
  end

  // Next-state and burst control strobes.
  always_comb begin
    state_d     = state_q;
    accept      = s_if.valid_in && !clear;
    start       = accept && (state_q != COLLECT);
    complete    = accept && ((state_q == COLLECT) ? ((count_out + CW'(1)) == exp_q)
                                                  : (exp_in == CW'(1)));
    timeout_hit = !clear && (state_q == COLLECT) && !s_if.valid_in && expired;
    finish      = complete || timeout_hit;
    idx         = start ? '0 : count_out;
    if (clear) begin
      state_d = IDLE;
    end else if (finish) begin
      state_d = DONE;
    end else if (start) begin
      state_d = COLLECT;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign busy = (state_q == COLLECT);

  // Statistics datapath. median_out follows every element up to the median
  // index, so a burst cut short before that index leaves the last element.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q       <= '0;
      med_idx_q   <= '0;
      stats_done  <= 1'b0;
      count_out   <= '0;
      min_out     <= '0;
      max_out     <= '0;
      median_out  <= '0;
      sum_out     <= '0;
      short_error <= 1'b0;
    end else if (clear) begin
      exp_q       <= '0;
      med_idx_q   <= '0;
      stats_done  <= 1'b0;
      count_out   <= '0;
      min_out     <= '0;
      max_out     <= '0;
      median_out  <= '0;
      sum_out     <= '0;
      short_error <= 1'b0;
    end else begin
      stats_done <= finish;
      if (timeout_hit) begin
        short_error <= 1'b1;
      end
      if (start) begin
        exp_q       <= exp_in;
        med_idx_q   <= med_idx_in;
        count_out   <= CW'(1);
        min_out     <= s_if.data_in;
        max_out     <= s_if.data_in;
        median_out  <= s_if.data_in;
        sum_out     <= SW'(s_if.data_in);
        short_error <= 1'b0;
      end else if (accept) begin
        count_out <= count_out + CW'(1);
        sum_out   <= sum_out + SW'(s_if.data_in);
        if (s_if.data_in < min_out) begin
          min_out <= s_if.data_in;
        end
        if (s_if.data_in > max_out) begin
          max_out <= s_if.data_in;
        end
        if (idx <= med_idx_q) begin
          median_out <= s_if.data_in;
        end
      end
    end
  end

`ifdef STATS_ORDER_CHECK_EN
  logic [DATA_WIDTH-1:0] prev_q;

  // Remember the last accepted element; flag any downward step within a burst.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q      <= '0;
      order_error <= 1'b0;
    end else if (clear) begin
      prev_q      <= '0;
      order_error <= 1'b0;
    end else if (start) begin
      prev_q      <= s_if.data_in;
      order_error <= 1'b0;
    end else if (accept) begin
      prev_q <= s_if.data_in;
      if (s_if.data_in < prev_q) begin
        order_error <= 1'b1;
      end
    end
  end
`else
  assign order_error = 1'b0;
`endif

endmodule

// File: tb/tb_sorted_stream_stats.sv
// Directed self-checking bench for sorted_stream_stats (default parameters).
module tb_sorted_stream_stats;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 5;
  localparam int unsigned SW = DW + CW;
`ifdef STATS_ORDER_CHECK_EN
  localparam logic ORD_EXP = 1'b1;
`else
  localparam logic ORD_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          busy, stats_done, order_error, short_error;
  logic [CW-1:0] count_out;
  logic [DW-1:0] min_out, max_out, median_out;
  logic [SW-1:0] sum_out;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  sorted_stream_stats_if #(.DATA_WIDTH(DW), .CNT_W(CW)) s_if ();

  sorted_stream_stats #(
    .DATA_WIDTH     (DW),
    .MAX_ARRAY_SIZE (16),
    .TIMEOUT        (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_if        (s_if.slave),
    .clear       (clear),
    .busy        (busy),
    .stats_done  (stats_done),
    .count_out   (count_out),
    .min_out     (min_out),
    .max_out     (max_out),
    .median_out  (median_out),
    .sum_out     (sum_out),
    .order_error (order_error),
    .short_error (short_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stream input, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [DW-1:0] d);
    s_if.valid_in = v;
    s_if.data_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stats(input string tag, input logic [63:0] c, input logic [63:0] mn,
                           input logic [63:0] mx, input logic [63:0] md, input logic [63:0] sm);
    chk({tag, ".count"},  64'(count_out),  c);
    chk({tag, ".min"},    64'(min_out),    mn);
    chk({tag, ".max"},    64'(max_out),    mx);
    chk({tag, ".median"}, 64'(median_out), md);
    chk({tag, ".sum"},    64'(sum_out),    sm);
  endtask

  initial begin
    reset              = 1'b1;
    clear              = 1'b0;
    s_if.valid_in      = 1'b0;
    s_if.data_in       = '0;
    s_if.expected_size = '0;

    #12;
    chk_stats("reset", 0, 0, 0, 0, 0);
    chk("reset.busy", 64'(busy), 0);
    chk("reset.done", 64'(stats_done), 0);
    chk("reset.order", 64'(order_error), 0);
    chk("reset.short", 64'(short_error), 0);
    @(negedge clk);
    reset = 1'b0;

    // Burst of six: 5,17,32,42,61,93
    s_if.expected_size = 5'd6;
    step(1'b1, 5);
    chk("b1.busy_first", 64'(busy), 1);
    chk("b1.count_first", 64'(count_out), 1);
    step(1'b1, 17);
    step(1'b1, 32);
    step(1'b1, 42);
    step(1'b1, 61);
    chk("b1.done_early", 64'(stats_done), 0);
    step(1'b1, 93);
    chk_stats("b1", 6, 5, 93, 32, 250);
    chk("b1.done", 64'(stats_done), 1);
    chk("b1.busy", 64'(busy), 0);
    chk("b1.order", 64'(order_error), 0);
    chk("b1.short", 64'(short_error), 0);

    // Back-to-back burst of four starts while stats_done is high
    s_if.expected_size = 5'd4;
    step(1'b1, 25);
    chk("b2.done_drop", 64'(stats_done), 0);
    chk("b2.count_first", 64'(count_out), 1);
    step(1'b1, 50);
    step(1'b1, 75);
    step(1'b1, 100);
    chk_stats("b2", 4, 25, 100, 50, 250);
    chk("b2.done", 64'(stats_done), 1);

    // Single-element burst
    s_if.expected_size = 5'd1;
    step(1'b1, 7);
    chk_stats("b3", 1, 7, 7, 7, 7);
    chk("b3.done", 64'(stats_done), 1);
    chk("b3.busy", 64'(busy), 0);
    step(1'b0, 0);
    chk("b3.done_drop", 64'(stats_done), 0);
    chk("b3.hold", 64'(count_out), 1);

    // expected_size 0 behaves as 1
    s_if.expected_size = 5'd0;
    step(1'b1, 42);
    chk("sz0.done", 64'(stats_done), 1);
    chk("sz0.count", 64'(count_out), 1);
    step(1'b0, 0);

    // Out-of-order burst 10,5,20
    s_if.expected_size = 5'd3;
    step(1'b1, 10);
    step(1'b1, 5);
    step(1'b1, 20);
    chk_stats("b4", 3, 5, 20, 5, 35);
    chk("b4.order", 64'(order_error), 64'(ORD_EXP));
    chk("b4.done", 64'(stats_done), 1);
    step(1'b0, 0);
    chk("b4.order_hold", 64'(order_error), 64'(ORD_EXP));

    // Short burst: size 4, only 3,9 then idle
    s_if.expected_size = 5'd4;
    step(1'b1, 3);
    chk("b5.order_cleared", 64'(order_error), 0);
    step(1'b1, 9);
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 0);
      chk("b5.idle_done", 64'(stats_done), 0);
      chk("b5.idle_busy", 64'(busy), 1);
    end
    step(1'b0, 0);
    chk("b5.done", 64'(stats_done), 1);
    chk("b5.short", 64'(short_error), 1);
    chk("b5.busy", 64'(busy), 0);
    chk_stats("b5", 2, 3, 9, 9, 12);
    step(1'b0, 0);
    chk("b5.done_drop", 64'(stats_done), 0);
    chk("b5.short_hold", 64'(short_error), 1);

    // Oversize request is clamped to 16: data 1..16
    s_if.expected_size = 5'd31;
    for (int i = 1; i <= 15; i++) begin
      step(1'b1, DW'(i));
    end
    chk("clamp.done_early", 64'(stats_done), 0);
    chk("clamp.short_cleared", 64'(short_error), 0);
    step(1'b1, 16);
    chk("clamp.done", 64'(stats_done), 1);
    chk_stats("clamp", 16, 1, 16, 8, 136);

    // clear together with the 3rd of 6 elements
    s_if.expected_size = 5'd6;
    step(1'b1, 1);
    step(1'b1, 2);
    clear = 1'b1;
    step(1'b1, 3);
    clear = 1'b0;
    chk_stats("clr", 0, 0, 0, 0, 0);
    chk("clr.busy", 64'(busy), 0);
    chk("clr.done", 64'(stats_done), 0);
    step(1'b0, 0);
    chk("clr.idle_done", 64'(stats_done), 0);
    s_if.expected_size = 5'd3;
    step(1'b1, 4);
    step(1'b1, 6);
    step(1'b1, 8);
    chk_stats("postclr", 3, 4, 8, 6, 18);
    chk("postclr.done", 64'(stats_done), 1);

    // Asynchronous reset mid-burst
    s_if.expected_size = 5'd3;
    step(1'b1, 100);
    step(1'b1, 200);
    #1;
    reset         = 1'b1;
    s_if.valid_in = 1'b0;
    #1;
    chk_stats("rst_mid", 0, 0, 0, 0, 0);
    chk("rst_mid.busy", 64'(busy), 0);
    #1;
    reset = 1'b0;
    step(1'b1, 1);
    step(1'b1, 2);
    step(1'b1, 3);
    chk_stats("postrst", 3, 1, 3, 2, 6);
    chk("postrst.done", 64'(stats_done), 1);
    step(1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sorted_stream_stats.md
# sorted_stream_stats

Downstream consumer of the dynamic array sorter's output stream. It accepts the ascending burst of sorted values, one per valid cycle, and produces summary statistics: count, min, max, lower median and sum. It optionally checks that the burst is non-decreasing, and flags bursts that end early. Results are held stable for the control/readout logic until the next burst or a clear.

## Interface
- DATA_WIDTH, 32, width of each data element
- MAX_ARRAY_SIZE, 16, maximum elements per burst
- TIMEOUT, 8, idle cycles inside a burst before it is declared short
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- valid_in  input  1  element strobe (driven by sorter valid_out)
- data_in  input  DATA_WIDTH  element value (sorter sorted_data_out)
- expected_size  input  $clog2(MAX_ARRAY_SIZE+1)  burst length (sorter array_size), sampled on first element
- clear  input  1  synchronous clear of results and state
- busy  output  1  burst in progress
- stats_done  output  1  one-cycle pulse when results are final
- count_out  output  $clog2(MAX_ARRAY_SIZE+1)  elements accepted
- min_out / max_out / median_out  output  DATA_WIDTH  statistics, unsigned
- sum_out  output  DATA_WIDTH+$clog2(MAX_ARRAY_SIZE+1)  unsigned sum, cannot overflow
- order_error  output  1  sticky per burst: element less than its predecessor
- short_error  output  1  burst ended by timeout before expected_size elements

## Operation
- States: IDLE, COLLECT, DONE.
- Reset: all outputs 0, state IDLE.
- **IDLE/DONE + valid_in:**
  - Start a new burst.
  - Latch expected_size, clamped to MAX_ARRAY_SIZE. An expected_size of 0 is treated as 1.
  - Clear errors.
  - Load the first element: min = max = sum = data_in, count = 1.
  - Median is captured if index 0 is the median index.
  - Go to COLLECT, or straight to DONE when the expected size is 1.
- **COLLECT + valid_in:**
  - count+1, sum += data_in, min/max update with unsigned compare.
  - Reset the idle counter.
- **Median:** median_out is captured from the element whose zero-based index equals (expected-1)>>1, i.e. the lower median.
- **Completion:** when count reaches the latched expected size, go to DONE and pulse stats_done.
- **Timeout:** in COLLECT, TIMEOUT consecutive cycles with valid_in low end the burst.
  - Go to DONE, pulse stats_done, set short_error.
  - If the median index was never reached, median_out holds the last accepted element.
- **DONE:** outputs are held; busy=0.
- **clear:** returns to IDLE with all outputs 0. It takes priority over valid_in in the same cycle, and that element is dropped.
- **Reset mid-burst:** immediate return to the reset values; the partial burst is discarded.

## Timing
- Every element is accepted in the cycle valid_in is high; there is no backpressure and no stall.
- Outputs are registered. With the last element sampled at edge N, count_out, min_out, max_out, sum_out, median_out and stats_done are all visible after edge N; stats_done drops after edge N+1.
- busy rises after the edge that samples the first element and falls together with the rise of stats_done.
- Timeout: with the last element sampled at edge N, stats_done rises after edge N+TIMEOUT.
- A valid_in in the same cycle stats_done is high starts a new burst. Results change from the next edge.

## Configuration
- STATS_ORDER_CHECK_EN defined: every element after the first is compared against the previous accepted element. order_error sets when it is strictly less, and stays set until the next burst start, clear or reset.
- Undefined: no comparator or previous-value register; order_error is tied to 0.

## Structure
- Package sorted_stats_pkg holds:
  - the state enum (IDLE, COLLECT, DONE)
  - the count and sum width localparams derived from DATA_WIDTH/MAX_ARRAY_SIZE, shared with dynamic_array_sorter users
- One sub-module, stats_idle_timer: idle counter with restart/clear inputs and an expired output.
- The datapath stays in the top.

## Test plan
- Burst 5,17,32,42,61,93, expected_size 6 -> count 6, min 5, max 93, median 32, sum 250, order_error 0, one stats_done pulse on the cycle after 93.
- Burst 25,50,75,100, expected_size 4 -> count 4, min 25, max 100, median 50, sum 250. Then a burst 7 with size 1 -> stats_done after the first edge, all stats 7.
- Burst 10,5,20, expected_size 3, with STATS_ORDER_CHECK_EN -> order_error 1. Without the macro -> order_error 0, other stats identical.
- expected_size 4, only 3,9 then idle, TIMEOUT 8 -> stats_done 8 cycles after 9, short_error 1, count 2, sum 12, median 9.
- clear asserted together with the 3rd of 6 elements -> all outputs 0, IDLE. The next valid starts a fresh burst with correct results.
- reset pulsed mid-burst, between clock edges -> outputs 0 immediately. A following full burst 1,2,3 -> median 2, sum 6.
